// File: rtl/hazard_stall_controller.sv
// ---------------------------------------------------------------------------
// hazard_stall_controller
//   Sequencing controller for the 5-stage RISC-V pipeline. It resolves the
//   hazards that forwarding cannot handle: load-use dependences, taken
//   branch/jump redirects and multi-cycle mul/div occupancy of EX. It drives
//   the PC / IF/ID / ID/EX enables, NOP-insertion controls and the mul/div
//   start strobe.
//
// Optional feature macro: STALL_COUNTERS_EN
//   Adds saturating load-use and mul/div stall counters (parameter CNT_W).
//
// Ports:
//   clk, rst                  core clock, async active-high reset
//   if_id_rs1/rs2, use_rs1/2  source registers of the instruction in ID
//   id_ex_rd, id_ex_memread   destination / load flag of the instruction in EX
//   id_ex_md, md_done         mul/div in EX, mul/div result valid
//   ex_branch_taken           EX resolved a taken branch/jump
//   pc_write, if_id_write,
//   id_ex_write               pipeline register enables
//   if_id_flush, id_ex_bubble,
//   ex_mem_bubble             NOP insertion controls
//   md_go                     one-cycle mul/div start pulse
//   md_busy                   controller waiting on mul/div
//   load_stall_cnt,
//   md_stall_cnt              stall statistics (macro only)
// ---------------------------------------------------------------------------
module hazard_stall_controller
`ifdef STALL_COUNTERS_EN
#(
    parameter int CNT_W = 32
)
`endif
(
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    input  logic             if_id_use_rs1,
    input  logic             if_id_use_rs2,
    input  logic [4:0]       id_ex_rd,
    input  logic             id_ex_memread,
    input  logic             id_ex_md,
    input  logic             md_done,
    input  logic             ex_branch_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_bubble,
    output logic             ex_mem_bubble,
    output logic             md_go,
    output logic             md_busy
`ifdef STALL_COUNTERS_EN
    ,
    output logic [CNT_W-1:0] load_stall_cnt,
    output logic [CNT_W-1:0] md_stall_cnt
`endif
);

    typedef enum logic {RUN, MD_WAIT} state_t;

    state_t r_state;
    state_t w_state_nxt;
    logic   w_load_use;
    logic   w_chk_hazards;

    assign w_load_use = id_ex_memread && (id_ex_rd != 5'd0) &&
                        ((if_id_use_rs1 && (if_id_rs1 == id_ex_rd)) ||
                         (if_id_use_rs2 && (if_id_rs2 == id_ex_rd)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= RUN;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_chk_hazards = 1'b0;
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_write   = 1'b1;
        id_ex_bubble  = 1'b0;
        ex_mem_bubble = 1'b0;
        md_go         = 1'b0;
        md_busy       = 1'b0;
        if (rst) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_write = 1'b0;
            w_state_nxt = RUN;
        end else begin
            case (r_state)
                RUN: begin
                    // EX holds a mul/div: it owns EX, so load/branch checks
                    // cannot apply to it this cycle.
                    if (id_ex_md) begin
                        md_go         = 1'b1;
                        ex_mem_bubble = 1'b1;
                        pc_write      = 1'b0;
                        if_id_write   = 1'b0;
                        id_ex_write   = 1'b0;
                        w_state_nxt   = MD_WAIT;
                    end else begin
                        w_chk_hazards = 1'b1;
                    end
                end
                MD_WAIT: begin
                    md_busy = 1'b1;
                    if (!md_done) begin
                        pc_write      = 1'b0;
                        if_id_write   = 1'b0;
                        id_ex_write   = 1'b0;
                        ex_mem_bubble = 1'b1;
                    end else begin
                        // Release cycle: EX/MEM captures the result and the
                        // front of the pipe behaves as in RUN.
                        w_state_nxt   = RUN;
                        w_chk_hazards = 1'b1;
                    end
                end
                default: w_state_nxt = RUN;
            endcase

            if (w_chk_hazards) begin
                // Redirect wins: the dependent instruction is on the wrong
                // path and gets squashed anyway.
                if (ex_branch_taken) begin
                    if_id_flush  = 1'b1;
                    id_ex_bubble = 1'b1;
                    pc_write     = 1'b1;
                end else if (w_load_use) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_bubble = 1'b1;
                    id_ex_write  = 1'b1;
                end
            end
        end
    end

`ifdef STALL_COUNTERS_EN
    logic w_ld_stall;
    logic w_md_stall;

    // Load-use is the only case that freezes the PC while ID/EX still loads;
    // mul/div stall cycles are exactly those bubbling EX/MEM.
    assign w_ld_stall = !pc_write && id_ex_write;
    assign w_md_stall = ex_mem_bubble;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_stall_cnt <= '0;
            md_stall_cnt   <= '0;
        end else begin
            if (w_ld_stall && (load_stall_cnt != {CNT_W{1'b1}}))
                load_stall_cnt <= load_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            if (w_md_stall && (md_stall_cnt != {CNT_W{1'b1}}))
                md_stall_cnt <= md_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
module tb_hazard_stall_controller;

`ifdef STALL_COUNTERS_EN
    localparam int          TB_CNT_W = 4;
    localparam int unsigned CMAX     = 15;
`else
    localparam int unsigned CMAX     = 32'hFFFF_FFFF;
`endif

    localparam logic [7:0] V_RUN  = 8'b1101_0000;
    localparam logic [7:0] V_LOAD = 8'b0001_1000;
    localparam logic [7:0] V_BR   = 8'b1111_1000;
    localparam logic [7:0] V_GO   = 8'b0000_0110;
    localparam logic [7:0] V_WAIT = 8'b0000_0101;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1, rs2, rd;
    logic       use1, use2, memread, md, done, br;
    logic       pc_write, if_id_write, if_id_flush, id_ex_write;
    logic       id_ex_bubble, ex_mem_bubble, md_go, md_busy;
`ifdef STALL_COUNTERS_EN
    logic [TB_CNT_W-1:0] load_stall_cnt, md_stall_cnt;
`endif
    logic [7:0] act;

    int n_cmp = 0;
    int n_bad = 0;

    bit          m_wait;
    int unsigned m_ld, m_md;

    always #5 clk = ~clk;

    assign act = {pc_write, if_id_write, if_id_flush, id_ex_write,
                  id_ex_bubble, ex_mem_bubble, md_go, md_busy};

`ifdef STALL_COUNTERS_EN
    hazard_stall_controller #(.CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst(rst),
        .if_id_rs1(rs1), .if_id_rs2(rs2),
        .if_id_use_rs1(use1), .if_id_use_rs2(use2),
        .id_ex_rd(rd), .id_ex_memread(memread), .id_ex_md(md),
        .md_done(done), .ex_branch_taken(br),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_write(id_ex_write), .id_ex_bubble(id_ex_bubble),
        .ex_mem_bubble(ex_mem_bubble), .md_go(md_go), .md_busy(md_busy),
        .load_stall_cnt(load_stall_cnt), .md_stall_cnt(md_stall_cnt)
    );
`else
    hazard_stall_controller dut (
        .clk(clk), .rst(rst),
        .if_id_rs1(rs1), .if_id_rs2(rs2),
        .if_id_use_rs1(use1), .if_id_use_rs2(use2),
        .id_ex_rd(rd), .id_ex_memread(memread), .id_ex_md(md),
        .md_done(done), .ex_branch_taken(br),
        .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_write(id_ex_write), .id_ex_bubble(id_ex_bubble),
        .ex_mem_bubble(ex_mem_bubble), .md_go(md_go), .md_busy(md_busy)
    );
`endif

    function automatic logic [7:0] exp_out();
        logic hz;
        hz = memread && (rd != 5'd0) &&
             ((use1 && rs1 == rd) || (use2 && rs2 == rd));
        if (rst)              return 8'b0;
        if (!m_wait && md)    return V_GO;
        if (m_wait && !done)  return V_WAIT;
        if (br)               return V_BR  | {7'b0, m_wait};
        if (hz)               return V_LOAD | {7'b0, m_wait};
        return V_RUN | {7'b0, m_wait};
    endfunction

    function automatic int unsigned sat_inc(input int unsigned x);
        return (x < CMAX) ? x + 1 : x;
    endfunction

    task automatic tick();
        logic [7:0] e;
        bit nw;
        int unsigned nl, nm;
        e = exp_out(); nw = m_wait; nl = m_ld; nm = m_md;
        if (rst) begin
            nw = 0; nl = 0; nm = 0;
        end else begin
            if (e == V_LOAD || e == (V_LOAD | 8'b1)) nl = sat_inc(nl);
            if (e[2]) nm = sat_inc(nm);
            if (e[1]) nw = 1;
            else if (m_wait && done) nw = 0;
        end
        @(posedge clk);
        m_wait = nw; m_ld = nl; m_md = nm;
        #1;
    endtask

    task automatic set_idle();
        rs1 = 0; rs2 = 0; rd = 0; use1 = 0; use2 = 0;
        memread = 0; md = 0; done = 0; br = 0;
    endtask

    task automatic assert_rst();
        rst = 1'b1; m_wait = 0; m_ld = 0; m_md = 0;
    endtask

    task automatic quick_reset();
        set_idle(); assert_rst(); tick(); rst = 1'b0;
    endtask

    task automatic test_reset();
        set_idle(); assert_rst();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if (act !== 8'b0) begin
                n_bad++; $display("FAIL reset_outs cyc%0d got=%b exp=%b", i, act, 8'b0);
            end
            tick();
        end
`ifdef STALL_COUNTERS_EN
        n_cmp++;
        if (load_stall_cnt !== 0 || md_stall_cnt !== 0) begin
            n_bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", load_stall_cnt, md_stall_cnt);
        end
`endif
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (act !== V_RUN) begin
            n_bad++; $display("FAIL reset_release got=%b exp=%b", act, V_RUN);
        end
        tick();
    endtask

    task automatic test_load_use();
        quick_reset();
        memread = 1; rd = 5; rs1 = 5; use1 = 1;
        @(negedge clk);
        n_cmp++;
        if (act !== V_LOAD) begin
            n_bad++; $display("FAIL load_use_stall got=%b exp=%b", act, V_LOAD);
        end
        tick();
        set_idle();
        @(negedge clk);
        n_cmp++;
        if (act !== V_RUN) begin
            n_bad++; $display("FAIL load_use_one_cycle got=%b exp=%b", act, V_RUN);
        end
        tick();
        memread = 1; rd = 0; rs1 = 0; use1 = 1;
        @(negedge clk);
        n_cmp++;
        if (act !== V_RUN) begin
            n_bad++; $display("FAIL load_use_rd0 got=%b exp=%b", act, V_RUN);
        end
        tick();
        memread = 1; rd = 9; rs1 = 3; rs2 = 9; use1 = 1; use2 = 1;
        @(negedge clk);
        n_cmp++;
        if (act !== V_LOAD) begin
            n_bad++; $display("FAIL load_use_rs2 got=%b exp=%b", act, V_LOAD);
        end
        tick();
        use2 = 0;
        @(negedge clk);
        n_cmp++;
        if (act !== V_RUN) begin
            n_bad++; $display("FAIL load_use_unused_rs2 got=%b exp=%b", act, V_RUN);
        end
        tick();
        set_idle();
`ifdef STALL_COUNTERS_EN
        n_cmp++;
        if (load_stall_cnt !== 2) begin
            n_bad++; $display("FAIL load_cnt got=%0d exp=2", load_stall_cnt);
        end
`endif
    endtask

    task automatic test_branch_override();
        set_idle();
        memread = 1; rd = 5; rs1 = 5; use1 = 1; br = 1;
        @(negedge clk);
        n_cmp++;
        if (act !== V_BR) begin
            n_bad++; $display("FAIL branch_override got=%b exp=%b", act, V_BR);
        end
        tick();
        set_idle();
    endtask

    task automatic test_muldiv();
        int pc_lo, gos;
        quick_reset();
        pc_lo = 0; gos = 0;
        md = 1;
        for (int c = 0; c < 6; c++) begin
            done = (c == 4);
            if (c == 5) md = 0;
            @(negedge clk);
            pc_lo += (pc_write == 1'b0);
            gos   += md_go;
            n_cmp++;
            if (act !== exp_out()) begin
                n_bad++; $display("FAIL muldiv_cyc%0d got=%b exp=%b", c, act, exp_out());
            end
            tick();
        end
        n_cmp++;
        if (pc_lo !== 4 || gos !== 1) begin
            n_bad++; $display("FAIL muldiv_len pc_lo=%0d go=%0d exp=4/1", pc_lo, gos);
        end
        n_cmp++;
        if (md_busy !== 1'b0) begin
            n_bad++; $display("FAIL muldiv_back_to_run busy=%b exp=0", md_busy);
        end
`ifdef STALL_COUNTERS_EN
        n_cmp++;
        if (md_stall_cnt !== 4) begin
            n_bad++; $display("FAIL md_cnt got=%0d exp=4", md_stall_cnt);
        end
`endif
        set_idle();
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [5];
        logic       dn  [5];
        logic       mm  [5];
        seq[0] = V_GO;  dn[0] = 0; mm[0] = 1;
        seq[1] = V_RUN | 8'b1; dn[1] = 1; mm[1] = 1;
        seq[2] = V_GO;  dn[2] = 0; mm[2] = 1;
        seq[3] = V_RUN | 8'b1; dn[3] = 1; mm[3] = 1;
        seq[4] = V_RUN; dn[4] = 0; mm[4] = 0;
        set_idle();
        for (int c = 0; c < 5; c++) begin
            md = mm[c]; done = dn[c];
            @(negedge clk);
            n_cmp++;
            if (act !== seq[c]) begin
                n_bad++; $display("FAIL back_to_back_cyc%0d got=%b exp=%b", c, act, seq[c]);
            end
            tick();
        end
        set_idle();
    endtask

    task automatic test_reset_mid_md();
        quick_reset();
        md = 1;
        tick();
        tick();
        assert_rst();
        #1;
        n_cmp++;
        if (act !== 8'b0) begin
            n_bad++; $display("FAIL rst_mid_md got=%b exp=%b", act, 8'b0);
        end
`ifdef STALL_COUNTERS_EN
        n_cmp++;
        if (load_stall_cnt !== 0 || md_stall_cnt !== 0) begin
            n_bad++; $display("FAIL rst_mid_md_cnt got=%0d/%0d exp=0/0", load_stall_cnt, md_stall_cnt);
        end
`endif
        set_idle();
        @(negedge clk);
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (act !== V_RUN) begin
            n_bad++; $display("FAIL rst_mid_md_restart got=%b exp=%b", act, V_RUN);
        end
        tick();
    endtask

`ifdef STALL_COUNTERS_EN
    task automatic test_saturation();
        quick_reset();
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) begin memread = 1; rd = 7; rs1 = 7; use1 = 1; end
            else set_idle();
            tick();
        end
        set_idle();
        n_cmp++;
        if (load_stall_cnt !== 4'd15) begin
            n_bad++; $display("FAIL load_cnt_sat got=%0d exp=15", load_stall_cnt);
        end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            set_idle();
            rst  = ($urandom_range(0, 99) == 0);
            if (rst) begin m_wait = 0; m_ld = 0; m_md = 0; end
            rs1  = 5'($urandom_range(0, 3));
            rs2  = 5'($urandom_range(0, 3));
            rd   = 5'($urandom_range(0, 3));
            use1 = 1'($urandom_range(0, 1));
            use2 = 1'($urandom_range(0, 1));
            if (m_wait) begin
                md   = 1;
                done = ($urandom_range(0, 2) == 0);
            end else begin
                md   = ($urandom_range(0, 7) == 0);
                done = ($urandom_range(0, 3) == 0);
            end
            memread = !md && ($urandom_range(0, 1) == 1);
            br      = !md && ($urandom_range(0, 4) == 0);
            @(negedge clk);
            n_cmp++;
            if (act !== exp_out()) begin
                n_bad++; $display("FAIL random_cyc%0d got=%b exp=%b", c, act, exp_out());
            end
`ifdef STALL_COUNTERS_EN
            n_cmp++;
            if (load_stall_cnt !== TB_CNT_W'(m_ld) || md_stall_cnt !== TB_CNT_W'(m_md)) begin
                n_bad++; $display("FAIL random_cnt_cyc%0d got=%0d/%0d exp=%0d/%0d",
                                  c, load_stall_cnt, md_stall_cnt, m_ld, m_md);
            end
`endif
            tick();
        end
        rst = 1'b0;
        set_idle();
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        m_wait = 0; m_ld = 0; m_md = 0;
        #1;
        test_reset();
        test_load_use();
        test_branch_override();
        test_muldiv();
        test_back_to_back();
        test_reset_mid_md();
`ifdef STALL_COUNTERS_EN
        test_saturation();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_stall_controller.md
# hazard_stall_controller

Pipeline sequencing controller for the 5-stage RISC-V core. It issues the stall, bubble and flush controls that the operand-forwarding logic cannot resolve alone: load-use hazards, taken branch/jump redirects, and multi-cycle mul/div occupancy of EX. It sits beside the forwarding unit and drives the PC register, IF/ID, ID/EX and EX/MEM pipeline-register enables, plus the start strobe of the mul/div unit.

## Interface
Parameters:
- CNT_W, 32, width of the stall counters (only present with `STALL_COUNTERS_EN`).

Ports (clock `clk` is the single clock; reset `rst` is asynchronous and active-high):
- clk  in  1  core clock.
- rst  in  1  async active-high reset.
- if_id_rs1  in  5  rs1 of the instruction in ID.
- if_id_rs2  in  5  rs2 of the instruction in ID.
- if_id_use_rs1  in  1  ID instruction reads rs1.
- if_id_use_rs2  in  1  ID instruction reads rs2.
- id_ex_rd  in  5  rd of the instruction in EX.
- id_ex_memread  in  1  EX instruction is a load.
- id_ex_md  in  1  EX instruction is mul/div.
- md_done  in  1  mul/div result valid this cycle.
- ex_branch_taken  in  1  EX resolved a taken branch/jump.
- pc_write  out  1  PC register enable.
- if_id_write  out  1  IF/ID enable.
- if_id_flush  out  1  load NOP into IF/ID.
- id_ex_write  out  1  ID/EX enable.
- id_ex_bubble  out  1  load NOP into ID/EX (when id_ex_write=1).
- ex_mem_bubble  out  1  load NOP into EX/MEM.
- md_go  out  1  one-cycle start pulse to mul/div unit.
- md_busy  out  1  controller is in MD_WAIT.
- load_stall_cnt  out  CNT_W  load-use stall cycles (macro only).
- md_stall_cnt  out  CNT_W  mul/div wait cycles (macro only).

## Operation
- States: RUN, MD_WAIT. Reset state RUN.
- Load-use hazard (RUN only): id_ex_memread=1, id_ex_rd≠0, and (use_rs1 and rs1==rd, or use_rs2 and rs2==rd). Response: pc_write=0, if_id_write=0, id_ex_bubble=1, id_ex_write=1. This lasts one cycle; on the next cycle the load is in MEM and forwarding covers the dependence.
- Branch taken (RUN only): if_id_flush=1, id_ex_bubble=1, pc_write=1. This overrides the load-use stall.
- Mul/div entry: in RUN with id_ex_md=1, md_go=1 and ex_mem_bubble=1 for that cycle; pc_write, if_id_write and id_ex_write=0; next state MD_WAIT.
- MD_WAIT, md_done=0: pc_write, if_id_write and id_ex_write=0; ex_mem_bubble=1; md_go=0; md_busy=1.
- MD_WAIT, md_done=1: all enables=1, ex_mem_bubble=0 (EX/MEM captures the result); next state RUN. Load-use and branch checks are evaluated in this cycle as in RUN.
- md_done in RUN is ignored. ex_branch_taken and id_ex_memread in MD_WAIT are ignored (EX holds the mul/div).
- Default in RUN with no event: all enables=1; bubbles, flush and md_go=0.

## Timing
- All outputs are combinational from the state and current inputs. The state register is updated on the rising edge of `clk`.
- While rst=1: pc_write, if_id_write and id_ex_write=0; bubbles, flush, md_go and md_busy=0; counters=0. State is forced to RUN asynchronously.
- Reset asserted mid-MD_WAIT aborts the wait. md_go is not reissued; the pipeline restarts from reset.
- Mul/div minimum latency: md_go at cycle N, earliest md_done at N+1. Stall length = cycles until md_done + 1 entry cycle.
- Back-to-back mul/div: the second one reaches EX the cycle after md_done and issues a new md_go.

## Configuration
- `STALL_COUNTERS_EN` defined:
  - load_stall_cnt increments on each load-use stall cycle.
  - md_stall_cnt increments on each cycle with pc_write=0 caused by mul/div (entry cycle plus MD_WAIT cycles with md_done=0).
  - Both counters saturate at all-ones and clear on rst.
- Undefined: the counter ports and logic are absent.

## Test plan
- Reset: hold rst for 3 cycles → write enables 0 and md_busy 0. Release → RUN, all enables 1.
- Load-use: id_ex_memread=1, id_ex_rd=5, rs1=5, use_rs1=1 → exactly one cycle with pc_write=0, if_id_write=0, id_ex_bubble=1. Same stimulus with rd=0 → no stall.
- Branch overrides load-use: stimulus above plus ex_branch_taken=1 → if_id_flush=1, id_ex_bubble=1, pc_write=1.
- Mul/div: id_ex_md=1, md_done raised 4 cycles after md_go → md_go for 1 cycle, pc_write=0 for 4 cycles, md_stall_cnt=4, RUN after md_done.
- Reset mid-MD_WAIT: assert rst 2 cycles after md_go → immediate RUN, md_busy=0, counters 0.
- Counter saturation (CNT_W=4, macro on): 20 load-use stalls → load_stall_cnt=15.
